// File: rtl/bb_seq_pkg.sv
// rtl/bb_seq_pkg.sv - shared types and constants for the baseball game sequencer
// Purpose: action-code constants, sequencer state enum, buffered tag layout
//          and a helper that packs a tag.
// Ports:   none (package)
package bb_seq_pkg;

   localparam logic [2:0] ACT_WALK   = 3'd0;
   localparam logic [2:0] ACT_SINGLE = 3'd1;
   localparam logic [2:0] ACT_DOUBLE = 3'd2;
   localparam logic [2:0] ACT_TRIPLE = 3'd3;
   localparam logic [2:0] ACT_HR     = 3'd4;
   localparam logic [2:0] ACT_BUNT   = 3'd5;
   localparam logic [2:0] ACT_GROUND = 3'd6;
   localparam logic [2:0] ACT_FLY    = 3'd7;

   typedef enum logic [1:0] {
      COLLECT  = 2'd0,
      PLAY     = 2'd1,
      WAIT_RES = 2'd2
   } seq_state_t;

   // Tag layout: {inning[1:0], half, code[2:0]}
   localparam int TAG_W          = 6;
   localparam int TAG_CODE_LSB   = 0;
   localparam int TAG_HALF_LSB   = 3;
   localparam int TAG_INNING_LSB = 4;

   function automatic logic [TAG_W-1:0] pack_tag(input logic [1:0] inning,
                                                 input logic       half,
                                                 input logic [2:0] code);
      return {inning, half, code};
   endfunction

endpackage

// File: rtl/bb_seq_fifo.sv
// rtl/bb_seq_fifo.sv - synchronous tag FIFO with flush for the game sequencer
// Purpose: holds one game's worth of tags between collection and replay.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write request and data (ignored when full)
//   pop, pop_data     read request; pop_data shows the head entry
//   flush             empties the FIFO (wins over push/pop)
//   full, empty       status
//   count             number of stored entries
module bb_seq_fifo
   import bb_seq_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int WIDTH = TAG_W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   // Pointers carry one extra MSB so full and empty are distinguishable
   // when the address bits match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full && !flush)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/bb_game_sequencer.sv
// rtl/bb_game_sequencer.sv - collects a game of action codes and replays it to the scorer
// Purpose: tracks outs/first base to tag each action with inning and half,
//          buffers a complete game, replays it as one gap-free burst, then
//          waits for the scorer's result.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   act_valid, act_ready, act_code    upstream action handshake
//   bb_in_valid, bb_inning, bb_half,
//   bb_action                         tagged game burst to the scorer
//   bb_out_valid                      scorer result strobe
//   busy                              replaying or awaiting the result
//   overflow                          one-cycle pulse when a game is discarded
//   games_done                        completed-game counter (wraps)
module bb_game_sequencer
   import bb_seq_pkg::*;
#(
   parameter int NUM_INNINGS = 3,
   parameter int DEPTH       = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       act_valid,
   output logic       act_ready,
   input  logic [2:0] act_code,
   output logic       bb_in_valid,
   output logic [1:0] bb_inning,
   output logic       bb_half,
   output logic [2:0] bb_action,
   input  logic       bb_out_valid,
   output logic       busy,
   output logic       overflow,
   output logic [7:0] games_done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] LAST_INNING = 2'(NUM_INNINGS);

   seq_state_t state;
   logic [1:0] inning;
   logic       half;
   logic [1:0] outs;
   logic       base1;

   logic             accept;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_flush;
   logic             fifo_full;
   logic             fifo_empty;
   logic [AW:0]      fifo_count;
   logic [TAG_W-1:0] fifo_pop_data;
   logic             last_pop;

   logic [1:0] outs_nx;
   logic       base1_nx;
   logic       half_end;
   logic       game_end;

   assign act_ready  = (state == COLLECT) && !rst;
   assign busy       = (state == PLAY) || (state == WAIT_RES);
   assign accept     = act_valid && act_ready;
   assign fifo_push  = accept && !fifo_full;
   assign fifo_flush = accept && fifo_full;
   assign fifo_pop   = (state == PLAY) && !fifo_empty;
   assign last_pop   = fifo_pop && (fifo_count == (AW+1)'(1));

   bb_seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (TAG_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (pack_tag(inning, half, act_code)),
      .pop       (fifo_pop),
      .pop_data  (fifo_pop_data),
      .flush     (fifo_flush),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Outs / first-base update for the action being accepted.
   always_comb begin
      outs_nx  = outs;
      base1_nx = base1;
      half_end = 1'b0;
      case (act_code)
         ACT_WALK, ACT_SINGLE: base1_nx = 1'b1;
         ACT_DOUBLE, ACT_TRIPLE, ACT_HR: base1_nx = 1'b0;
         ACT_BUNT: begin
            outs_nx  = outs + 2'd1;
            base1_nx = 1'b0;
         end
         ACT_GROUND: begin
            if (base1 && outs != 2'd0) begin
               half_end = 1'b1;               // double play retires the side
            end else if (base1) begin
               outs_nx  = 2'd2;
               base1_nx = 1'b0;
            end else begin
               outs_nx  = outs + 2'd1;
            end
         end
         default: begin                       // ACT_FLY
            outs_nx  = outs + 2'd1;
            base1_nx = (outs < 2'd2) ? base1 : 1'b0;
         end
      endcase
      if (outs_nx == 2'd3)
         half_end = 1'b1;
   end

   assign game_end = half_end && half && (inning == LAST_INNING);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= COLLECT;
         inning      <= 2'd1;
         half        <= 1'b0;
         outs        <= 2'd0;
         base1       <= 1'b0;
         overflow    <= 1'b0;
         games_done  <= 8'd0;
         bb_in_valid <= 1'b0;
         bb_inning   <= 2'd0;
         bb_half     <= 1'b0;
         bb_action   <= 3'd0;
      end else begin
         overflow    <= 1'b0;
         bb_in_valid <= 1'b0;
         bb_inning   <= 2'd0;
         bb_half     <= 1'b0;
         bb_action   <= 3'd0;
         case (state)
            COLLECT: begin
               if (accept && fifo_full) begin
                  // Game too long to buffer: drop it and start over.
                  overflow <= 1'b1;
                  inning   <= 2'd1;
                  half     <= 1'b0;
                  outs     <= 2'd0;
                  base1    <= 1'b0;
               end else if (accept && half_end) begin
                  outs  <= 2'd0;
                  base1 <= 1'b0;
                  if (game_end) begin
                     inning <= 2'd1;
                     half   <= 1'b0;
                     state  <= PLAY;
                  end else if (half) begin
                     inning <= inning + 2'd1;
                     half   <= 1'b0;
                  end else begin
                     half   <= 1'b1;
                  end
               end else if (accept) begin
                  outs  <= outs_nx;
                  base1 <= base1_nx;
               end
            end
            PLAY: begin
               if (fifo_pop) begin
                  bb_in_valid <= 1'b1;
                  bb_inning   <= fifo_pop_data[TAG_INNING_LSB +: 2];
                  bb_half     <= fifo_pop_data[TAG_HALF_LSB];
                  bb_action   <= fifo_pop_data[TAG_CODE_LSB +: 3];
               end
               if (last_pop || fifo_empty)
                  state <= WAIT_RES;
            end
            WAIT_RES: begin
               if (bb_out_valid) begin
                  games_done <= games_done + 8'd1;
                  state      <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_bb_game_sequencer.sv
// tb/tb_bb_game_sequencer.sv - directed self-checking bench for bb_game_sequencer
module tb_bb_game_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       act_valid;
   logic       act_ready;
   logic [2:0] act_code;
   logic       bb_in_valid;
   logic [1:0] bb_inning;
   logic       bb_half;
   logic [2:0] bb_action;
   logic       bb_out_valid;
   logic       busy;
   logic       overflow;
   logic [7:0] games_done;

   int n_checks = 0;
   int n_errors = 0;
   logic [5:0] exp_q[$];

   bb_game_sequencer #(.NUM_INNINGS(3), .DEPTH(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .act_valid    (act_valid),
      .act_ready    (act_ready),
      .act_code     (act_code),
      .bb_in_valid  (bb_in_valid),
      .bb_inning    (bb_inning),
      .bb_half      (bb_half),
      .bb_action    (bb_action),
      .bb_out_valid (bb_out_valid),
      .busy         (busy),
      .overflow     (overflow),
      .games_done   (games_done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] c);
      act_valid = 1'b1;
      act_code  = c;
      step();
      act_valid = 1'b0;
   endtask

   task automatic push_exp(input int inn, input int h, input int code, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({inn[1:0], h[0], code[2:0]});
   endtask

   task automatic std_game_exp();
      exp_q.delete();
      for (int inn = 1; inn <= 3; inn++)
         for (int h = 0; h < 2; h++)
            push_exp(inn, h, 7, 3);
   endtask

   // Called one step after the game-ending accept; checks the burst and result handshake.
   task automatic replay(input int delay, input int gd_exp);
      int w;
      int acc;
      acc = 0;
      check("ready_drop", act_ready, 0);
      check("busy_play", busy, 1);
      w = 0;
      while (!bb_in_valid && w < 6) begin
         if (act_valid && act_ready) acc++;
         step();
         w++;
      end
      check("first_latency", w, 1);
      foreach (exp_q[i]) begin
         check("burst_valid", bb_in_valid, 1);
         check("burst_tag", {bb_inning, bb_half, bb_action}, exp_q[i]);
         if (act_valid && act_ready) acc++;
         step();
      end
      check("tail_valid", bb_in_valid, 0);
      check("tail_tag", {bb_inning, bb_half, bb_action}, 0);
      check("busy_wait", busy, 1);
      for (int i = 0; i < delay; i++) begin
         if (act_valid && act_ready) acc++;
         step();
      end
      bb_out_valid = 1'b1;
      step();
      bb_out_valid = 1'b0;
      check("games_done", games_done, gd_exp);
      check("ready_back", act_ready, 1);
      act_valid = 1'b0;
      check("held_accepts", acc, 0);
   endtask

   initial begin
      rst          = 1'b1;
      act_valid    = 1'b0;
      act_code     = 3'd0;
      bb_out_valid = 1'b0;
      #12;
      check("rst_ready", act_ready, 0);
      check("rst_valid", bb_in_valid, 0);
      check("rst_tag", {bb_inning, bb_half, bb_action}, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      check("rst_games", games_done, 0);
      step();
      rst = 1'b0;
      #1;
      check("ready_after_rst", act_ready, 1);

      // 18 fly balls: three outs per half, three innings
      std_game_exp();
      repeat (18) send(3'd7);
      replay(0, 1);

      // walk/ground/fly then fly/walk/double-play, then 12 flies; act_valid held through replay
      exp_q.delete();
      push_exp(1, 0, 0, 1); push_exp(1, 0, 6, 1); push_exp(1, 0, 7, 1);
      push_exp(1, 1, 7, 1); push_exp(1, 1, 0, 1); push_exp(1, 1, 6, 1);
      push_exp(2, 0, 7, 3); push_exp(2, 1, 7, 3);
      push_exp(3, 0, 7, 3); push_exp(3, 1, 7, 3);
      send(3'd0); send(3'd6); send(3'd7);
      send(3'd7); send(3'd0); send(3'd6);
      repeat (12) send(3'd7);
      act_valid = 1'b1;
      act_code  = 3'd7;
      replay(5, 2);

      // overflow: 64 walks fill the buffer, the 65th discards the game
      repeat (64) send(3'd0);
      check("ovf_before", overflow, 0);
      act_valid = 1'b1;
      act_code  = 3'd0;
      step();
      act_valid = 1'b0;
      check("ovf_pulse", overflow, 1);
      check("ovf_ready", act_ready, 1);
      check("ovf_busy", busy, 0);
      step();
      check("ovf_once", overflow, 0);
      check("ovf_games", games_done, 2);
      std_game_exp();
      repeat (18) send(3'd7);
      replay(0, 3);

      // reset during the 5th PLAY cycle
      repeat (18) send(3'd7);
      repeat (4) step();
      check("pre_rst_valid", bb_in_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_valid", bb_in_valid, 0);
      check("async_tag", {bb_inning, bb_half, bb_action}, 0);
      check("async_ready", act_ready, 0);
      check("async_busy", busy, 0);
      check("async_games", games_done, 0);
      check("async_ovf", overflow, 0);
      step();
      rst = 1'b0;
      #1;
      check("post_rst_ready", act_ready, 1);
      std_game_exp();
      repeat (18) send(3'd7);
      replay(0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bb_game_sequencer.md
# bb_game_sequencer

Front-end controller for the baseball scorer. Accepts a free-running stream of action codes, tracks outs and first-base occupancy to infer inning/half boundaries, and buffers each complete game. It then replays the game to the scorer as one contiguous in_valid burst, tagged with inning and half, and waits for the scorer's result before taking the next game. This decouples irregular upstream producers from the scorer's requirement that in_valid never drop mid-game.

## Interface
Parameters:
- NUM_INNINGS, 3, innings per game; range 1..3 (2-bit inning field).
- DEPTH, 64, game buffer entries; power of 2, ≥ 6·NUM_INNINGS.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- act_valid  in  1  upstream action valid.
- act_ready  out  1  sequencer can accept an action.
- act_code  in  3  action code: 0 walk, 1 single, 2 double, 3 triple, 4 HR, 5 bunt, 6 ground ball, 7 fly ball.
- bb_in_valid  out  1  to scorer, high for every cycle of the game burst.
- bb_inning  out  2  to scorer, inning 1..NUM_INNINGS.
- bb_half  out  1  to scorer; 0 top, 1 bottom.
- bb_action  out  3  to scorer, action code.
- bb_out_valid  in  1  scorer result valid.
- busy  out  1  state is PLAY or WAIT_RES.
- overflow  out  1  one-cycle pulse when a game is discarded.
- games_done  out  8  completed-game count; wraps 255→0.

## Operation
- States:
  - COLLECT: resets here.
  - PLAY: entered the cycle after the game-ending action is accepted.
  - WAIT_RES: entered the cycle after the last entry is popped.
  - WAIT_RES → COLLECT: the cycle after bb_out_valid=1.
- act_ready = 1 only in COLLECT and not in reset. Accept = act_valid & act_ready.
- Each accepted action is written as the tag {inning, half, code}, using the inning/half values before the update.
- Out/base1 tracking, per accepted action:
  - Codes 0–4: outs unchanged. Codes 0 and 1 set base1; codes 2–4 clear it.
  - Code 5: outs+1, base1=0.
  - Code 6 with base1=1 and outs≥1: half ends (double play).
  - Code 6 with base1=1 and outs=0: outs=2, base1=0.
  - Code 6 with base1=0: outs+1.
  - Code 7: outs+1; base1 is kept if outs<2.
  - When outs reaches 3: outs=0, base1=0, half toggles; inning+1 when leaving the bottom half.
- Game end: the half ends in the bottom of NUM_INNINGS. The ending action is buffered, then the state goes to PLAY.
- Overflow: accept while FIFO is full and the game is incomplete.
  - The action is dropped, overflow pulses.
  - FIFO is flushed; inning=1, half=0, outs=0, base1=0.
  - State stays COLLECT.
- PLAY: pop one entry per cycle. bb_* outputs are registered from the popped entry.
- bb_out_valid is ignored outside WAIT_RES. In WAIT_RES it increments games_done.

## Timing
- Reset values:
  - act_ready 0; bb_in_valid 0; bb_inning 0; bb_half 0; bb_action 0.
  - busy 0; overflow 0; games_done 0.
  - Internal: inning=1, half=0, outs=0, base1=0, FIFO empty, state COLLECT.
- Game-ending accept at cycle N:
  - act_ready=0 from N+1.
  - First bb_in_valid at N+2.
  - bb_in_valid high for exactly K consecutive cycles, K = buffered entries. No bubbles.
- bb_* outputs return to 0 the cycle after the last entry.
- bb_out_valid at cycle M → act_ready=1 and games_done updated at M+1.
- Reset asserted mid-PLAY: bb_in_valid falls asynchronously and the buffered game is lost.

## Structure
- Package bb_seq_pkg holds:
  - action-code localparams (ACT_WALK … ACT_FLY);
  - state enum {COLLECT, PLAY, WAIT_RES};
  - tag width TAG_W=6 and field offsets.
- Sub-module bb_seq_fifo: synchronous FIFO, DEPTH×TAG_W, with push, pop, flush, full and empty. Pointers are one bit wider than the address; wrap-around is handled by the MSB.

## Test plan
- 18 × code 7 → bb_in_valid high 18 consecutive cycles, with tags:
  - (1,0)×3, (1,1)×3, (2,0)×3, (2,1)×3, (3,0)×3, (3,1)×3;
  - then bb_out_valid → games_done=1; act_ready=1 the next cycle.
- Codes 0, 6, 7 in the top of the 1st → walk, then outs=2 after the 6, then the half ends on the 7. The next action is tagged (1,1).
- Codes 7, 0, 6 → the double play ends the half after 3 actions. The next tag is half=1, outs=0.
- 64 × code 0, then one more code 0 (DEPTH=64):
  - overflow pulses once; FIFO is empty;
  - the next accepted action is tagged (1,0);
  - games_done is unchanged.
- act_valid held high through PLAY and WAIT_RES, with bb_out_valid delayed 5 cycles → zero accepts until the cycle after bb_out_valid.
- rst pulsed during the 5th PLAY cycle → bb_in_valid=0 immediately and all outputs at reset values. The next full 18-action game replays correctly.
